// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : FIFO-buffered ALU command sequencer; issues buffered commands
//            back-to-back on start as a registered valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int OP_W  = 3,
    parameter int A_W   = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [OP_W-1:0]            push_op,
    input  logic [A_W-1:0]             push_a,
    input  logic                       start,
    input  logic                       abort,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       busy,
    output logic                       issue_valid,
    output logic [OP_W-1:0]            issue_op,
    output logic [A_W-1:0]             issue_a,
    output logic                       done
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_CMD_W = OP_W + A_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CMD_W-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_push_ok;
    logic                 w_pop;

    assign full  = (r_count == c_CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign busy  = (r_state != S_IDLE);

    // abort wins over a same-edge push, and the discarded push is not an overflow
    always_comb begin
        w_push_ok = push && !full && !abort;
        w_pop     = (r_state == S_ISSUE) && !abort;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!abort && start && !empty) w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (abort)
                    w_state_next = S_IDLE;
                else if (r_count == c_CNT_W'(1) && !w_push_ok)
                    w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= {push_op, push_a};
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            overflow <= 1'b0;
        end else if (abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push && full) overflow <= 1'b1;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // issue_op/issue_a hold their last value while issue_valid is low
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            issue_valid <= 1'b0;
            issue_op    <= '0;
            issue_a     <= '0;
            done        <= 1'b0;
        end else begin
            issue_valid <= w_pop;
            done        <= (r_state == S_DONE) && !abort;
            if (w_pop) {issue_op, issue_a} <= r_mem[r_rd_ptr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Directed plus randomized bench for alu_op_sequencer against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam int DEPTH = 4;
    localparam int OP_W  = 3;
    localparam int A_W   = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                push = 1'b0;
    logic [OP_W-1:0]     push_op = '0;
    logic [A_W-1:0]      push_a = '0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic                full;
    logic                empty;
    logic [CNT_W-1:0]    count;
    logic                overflow;
    logic                busy;
    logic                issue_valid;
    logic [OP_W-1:0]     issue_op;
    logic [A_W-1:0]      issue_a;
    logic                done;

    int n_checks = 0;
    int n_errors = 0;

    alu_op_sequencer #(.DEPTH(DEPTH), .OP_W(OP_W), .A_W(A_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .push        (push),
        .push_op     (push_op),
        .push_a      (push_a),
        .start       (start),
        .abort       (abort),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .busy        (busy),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_a     (issue_a),
        .done        (done)
    );

    always #5 clock = ~clock;

    // Reference model: a command queue plus "running" / "finishing" run phases
    logic [OP_W+A_W-1:0] m_q[$];
    bit                  m_run = 1'b0;
    bit                  m_finish = 1'b0;
    bit                  m_ovf = 1'b0;
    bit                  m_valid = 1'b0;
    bit                  m_done = 1'b0;
    logic [OP_W-1:0]     m_op = '0;
    logic [A_W-1:0]      m_a = '0;
    int                  m_done_pulses = 0;
    int                  m_issues = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit p, input logic [OP_W+A_W-1:0] cmd,
                              input bit s, input bit ab, input bit rn);
        bit was_idle, was_full, was_empty;
        logic [OP_W+A_W-1:0] head;
        if (!rn) begin
            m_q.delete();
            m_run = 0; m_finish = 0; m_ovf = 0;
            m_valid = 0; m_done = 0; m_op = '0; m_a = '0;
            return;
        end
        if (ab) begin
            m_q.delete();
            m_run = 0; m_finish = 0; m_valid = 0; m_done = 0;
            return;
        end
        was_idle  = !m_run && !m_finish;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        m_done    = m_finish;
        m_finish  = 0;
        m_valid   = 0;
        if (m_run) begin
            head = m_q.pop_front();
            {m_op, m_a} = head;
            m_valid = 1;
        end
        if (p) begin
            if (was_full) m_ovf = 1;
            else          m_q.push_back(cmd);
        end
        if (m_run && m_q.size() == 0) begin
            m_run = 0;
            m_finish = 1;
        end else if (was_idle && s && !was_empty) begin
            m_run = 1;
        end
        if (m_done)  m_done_pulses++;
        if (m_valid) m_issues++;
    endtask

    task automatic check_all();
        check_eq("count",       32'(count),       32'(m_q.size()));
        check_eq("full",        32'(full),        32'(m_q.size() == DEPTH));
        check_eq("empty",       32'(empty),       32'(m_q.size() == 0));
        check_eq("overflow",    32'(overflow),    32'(m_ovf));
        check_eq("busy",        32'(busy),        32'(m_run || m_finish));
        check_eq("issue_valid", 32'(issue_valid), 32'(m_valid));
        check_eq("issue_op",    32'(issue_op),    32'(m_op));
        check_eq("issue_a",     32'(issue_a),     32'(m_a));
        check_eq("done",        32'(done),        32'(m_done));
    endtask

    task automatic cycle(input bit p, input logic [OP_W-1:0] o, input logic [A_W-1:0] av,
                         input bit s, input bit ab, input bit rn);
        push = p; push_op = o; push_a = av; start = s; abort = ab; reset_n = rn;
        @(posedge clock);
        model_edge(p, {o, av}, s, ab, rn);
        #1 check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, 0, 1);
    endtask

    task automatic do_reset();
        cycle(0, '0, '0, 0, 0, 0);
        cycle(0, '0, '0, 0, 0, 0);
    endtask

    initial begin
        int base_done, base_issue;

        // reset then idle
        do_reset();
        idle(2);

        // basic run of three commands
        cycle(1, 3'b000, 4'h3, 0, 0, 1);
        cycle(1, 3'b010, 4'h5, 0, 0, 1);
        cycle(1, 3'b111, 4'hF, 0, 0, 1);
        base_done = m_done_pulses; base_issue = m_issues;
        cycle(0, '0, '0, 1, 0, 1);
        idle(6);
        check_eq("basic_issues", 32'(m_issues - base_issue), 32'd3);
        check_eq("basic_done_pulses", 32'(m_done_pulses - base_done), 32'd1);

        // full and overflow
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, OP_W'(i), A_W'(i + 8), 0, 0, 1);
        base_issue = m_issues;
        cycle(0, '0, '0, 1, 0, 1);
        idle(7);
        check_eq("ovf_issues", 32'(m_issues - base_issue), 32'd4);

        // push during issue
        do_reset();
        cycle(1, 3'b001, 4'h1, 0, 0, 1);
        cycle(1, 3'b011, 4'h4, 0, 0, 1);
        base_done = m_done_pulses; base_issue = m_issues;
        cycle(0, '0, '0, 1, 0, 1);
        cycle(1, 3'b101, 4'h2, 0, 0, 1);
        idle(5);
        check_eq("pdi_issues", 32'(m_issues - base_issue), 32'd3);
        check_eq("pdi_done_pulses", 32'(m_done_pulses - base_done), 32'd1);

        // abort mid-run
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, OP_W'(7 - i), A_W'(i * 3), 0, 0, 1);
        base_done = m_done_pulses;
        cycle(0, '0, '0, 1, 0, 1);
        idle(2);
        cycle(0, '0, '0, 0, 1, 1);
        idle(2);
        cycle(0, '0, '0, 1, 0, 1);
        idle(3);
        check_eq("abort_done_pulses", 32'(m_done_pulses - base_done), 32'd0);

        // start while empty, then start with abort
        do_reset();
        base_issue = m_issues;
        cycle(0, '0, '0, 1, 0, 1);
        idle(1);
        cycle(1, 3'b110, 4'h9, 0, 0, 1);
        cycle(0, '0, '0, 1, 1, 1);
        idle(3);
        check_eq("simul_issues", 32'(m_issues - base_issue), 32'd0);

        // randomized traffic, including occasional mid-run resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r_p, r_s, r_ab, r_rn;
            r_p  = ($urandom_range(0, 99) < 45) ? 1 : 0;
            r_s  = ($urandom_range(0, 99) < 12) ? 1 : 0;
            r_ab = ($urandom_range(0, 99) < 3)  ? 1 : 0;
            r_rn = ($urandom_range(0, 199) < 1) ? 0 : 1;
            cycle(bit'(r_p), OP_W'($urandom_range(0, 7)), A_W'($urandom_range(0, 15)),
                  bit'(r_s), bit'(r_ab), bit'(r_rn));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Upstream command sequencer for the 8-bit ALU result-register stage. Buffers up to DEPTH ALU commands (3-bit function select plus 4-bit A operand) in a FIFO. On `start`, it issues them back-to-back, one per cycle, as a registered valid strobe. The ALU stage uses `issue_valid` as its register load enable and consumes `issue_op`/`issue_a` as its select and A inputs.

## Interface
- DEPTH, 4: FIFO entries; power of two, minimum 2
- OP_W, 3: function-select width
- A_W, 4: A operand width
- clock  in  1  system clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- push  in  1  write {push_op, push_a} into FIFO this cycle
- push_op  in  OP_W  command function select
- push_a  in  A_W  command A operand
- start  in  1  begin issuing buffered commands
- abort  in  1  stop issuing and flush FIFO
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- count  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a push was dropped because FIFO was full
- busy  out  1  state is ISSUE or DONE
- issue_valid  out  1  issue_op/issue_a valid; ALU register loads this cycle
- issue_op  out  OP_W  issued function select
- issue_a  out  A_W  issued A operand
- done  out  1  one-cycle pulse after last command of a run is issued

## Operation
- FIFO: circular buffer with rd/wr pointers and a separate occupancy counter. full = (count==DEPTH). empty = (count==0). Pointers wrap modulo DEPTH.
- Push is accepted in any state when full==0 (value before the edge). Push when full is dropped, FIFO is unchanged, and overflow is set to 1. Only reset clears overflow.
- Push and pop on the same edge: both occur and count is unchanged. Push-while-full with a same-edge pop is still dropped, because the decision uses pre-edge full.
- FSM states: IDLE, ISSUE, DONE.
- IDLE: start==1 and empty==0 moves to ISSUE. start while empty is ignored, and the FSM stays in IDLE.
- ISSUE: every edge pops the head entry. issue_op/issue_a take the head fields and issue_valid is set to 1.
  - If that pop leaves count==0 with no same-edge push, the next state is DONE.
  - Entries pushed during ISSUE are issued in the same run.
- DONE: on the next edge, issue_valid goes to 0, done goes to 1, and the state returns to IDLE. done returns to 0 one edge later.
- start is ignored outside IDLE.
- abort in ISSUE or DONE: on that edge the state goes to IDLE, issue_valid goes to 0, the FIFO is flushed (pointers and count set to 0), and done stays 0. abort beats a same-edge push, which is discarded without setting overflow.
- abort in IDLE also flushes the FIFO. abort beats start.
- issue_op/issue_a hold their last issued value when issue_valid==0.

## Timing
- Reset (reset_n==0 at an edge) sets:
  - state IDLE
  - count 0, empty 1, full 0, overflow 0
  - issue_valid 0, issue_op 0, issue_a 0
  - busy 0, done 0
  - pointers 0
  - FIFO storage contents are don't-care.
- Reset mid-run abandons all entries, and no done pulse is produced.
- All outputs are registered or decoded purely from registers. There is no combinational path from inputs to outputs.
- Latency and run shape:
  - start sampled at edge k: busy=1 after edge k.
  - First issue_valid=1 after edge k+1.
  - A run of N entries with no pushes during ISSUE gives issue_valid high after edges k+1 through k+N, then done=1 after edge k+N+1, with busy=0 after that same edge.
- Throughput: one command per cycle, with no bubbles inside a run.
- A pushed entry is visible in count after the edge that accepts it. It can be issued at the earliest on the following edge.

## Test plan
- Reset then idle:
  - Stimulus: hold reset_n=0 for 2 edges, then release.
  - Required: count=0, empty=1, issue_valid=0, done=0, overflow=0.
- Basic run:
  - Stimulus: push (op=000,a=3), (op=010,a=5), (op=111,a=F); pulse start.
  - Required: issue_valid high for exactly 3 consecutive cycles, carrying those values in order; done pulses once in the next cycle; count=0 and busy=0 afterwards.
- Full/overflow:
  - Stimulus: push 5 entries with DEPTH=4.
  - Required: full=1 after the 4th push; the 5th is dropped; overflow=1; the run issues exactly the first 4 entries.
- Push during ISSUE:
  - Stimulus: 2 entries buffered; start; push (op=101,a=2) in the first ISSUE cycle.
  - Required: 3 consecutive issues, the third being (101,2); then a single done pulse.
- Abort mid-run:
  - Stimulus: 4 entries; start; assert abort after the 2nd issue.
  - Required: issue_valid=0 on the next edge; count=0; no done pulse; a later start with empty FIFO does nothing.
- Simultaneous events:
  - Stimulus: start with empty FIFO; then start and abort together with 1 entry buffered.
  - Required: both are ignored and flushed respectively; issue_valid never asserts.
